// File: rtl/mem_data_memory_sync.sv
// Clocked big-endian data memory for the MEM stage.
// A request is accepted in idle, held for WAIT_CYCLES cycles, then answered with a
// one-cycle resp_valid pulse. Byte, half and word accesses are supported, loads are sign-
// or zero-extended, and misaligned, out-of-range, reserved-size or read+write requests
// complete with error set and no side effect.
module mem_data_memory_sync #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            access_size,
  input  logic                  load_unsigned,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  resp_valid,
  output logic                  busy,
  output logic                  error
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  // Counter preload so that exactly WAIT_CYCLES cycles are spent in StWait.
  localparam logic [3:0] WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  localparam logic [1:0] SizeWord = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeByte = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e state_q;
  logic [3:0] cnt_q;

  // Latched request.
  logic                  rd_q;
  logic                  wr_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  // Byte storage; not cleared by reset.
  logic [7:0] mem [Depth];

  // The request currently being served: live inputs in idle (so a zero-wait access can be
  // answered straight from the accept edge), the latched copy otherwise.
  logic                  acc_rd;
  logic                  acc_wr;
  logic [1:0]            acc_size;
  logic                  acc_uns;
  logic [31:0]           acc_addr;
  logic                  acc_err;
  logic                  req_live;
  logic                  go_resp;

  logic [ADDR_WIDTH-1:0] a0;
  logic [ADDR_WIDTH-1:0] a1;
  logic [ADDR_WIDTH-1:0] a2;
  logic [ADDR_WIDTH-1:0] a3;
  logic [7:0]            b0;
  logic [7:0]            b1;
  logic [7:0]            b2;
  logic [7:0]            b3;
  logic                  ext;
  logic [DATA_WIDTH-1:0] load_val;

  assign req_live = mem_read | mem_write;

  // Select which copy of the request the datapath looks at.
  always_comb begin
    if (state_q == StIdle) begin
      acc_rd   = mem_read;
      acc_wr   = mem_write;
      acc_size = access_size;
      acc_uns  = load_unsigned;
      acc_addr = address;
    end else begin
      acc_rd   = rd_q;
      acc_wr   = wr_q;
      acc_size = size_q;
      acc_uns  = uns_q;
      acc_addr = addr_q;
    end
  end

  // Error classification of the served request.
  always_comb begin
    acc_err = 1'b0;
    if ((acc_addr >> ADDR_WIDTH) != 32'd0) acc_err = 1'b1;
    if (acc_size == 2'b11) acc_err = 1'b1;
    if (acc_size == SizeWord && acc_addr[1:0] != 2'b00) acc_err = 1'b1;
    if (acc_size == SizeHalf && acc_addr[0] != 1'b0) acc_err = 1'b1;
    if (acc_rd && acc_wr) acc_err = 1'b1;
  end

  // Byte lanes of the access, lowest address first (most significant byte).
  always_comb begin
    a0 = acc_addr[ADDR_WIDTH-1:0];
    a1 = a0 + ADDR_WIDTH'(1);
    a2 = a0 + ADDR_WIDTH'(2);
    a3 = a0 + ADDR_WIDTH'(3);
    b0 = mem[a0];
    b1 = mem[a1];
    b2 = mem[a2];
    b3 = mem[a3];
  end

  // Extend the loaded field; for both half and byte its MSB is bit 7 of the first byte.
  always_comb begin
    ext = ~acc_uns & b0[7];
    unique case (acc_size)
      SizeWord: load_val = {b0, b1, b2, b3};
      SizeHalf: load_val = {{16{ext}}, b0, b1};
      SizeByte: load_val = {{24{ext}}, b0};
      default:  load_val = '0;
    endcase
  end

  // Edge on which the FSM enters StResp; load data and status are registered here.
  always_comb begin
    go_resp = 1'b0;
    if (state_q == StIdle && req_live && WAIT_CYCLES == 0) go_resp = 1'b1;
    if (state_q == StWait && cnt_q == 4'd0) go_resp = 1'b1;
  end

  // Busy covers the accept cycle (combinationally) and every wait cycle, never StResp.
  always_comb begin
    busy = 1'b0;
    if (state_q == StIdle && req_live) busy = 1'b1;
    if (state_q == StWait) busy = 1'b1;
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= '0;
      read_data  <= '0;
      resp_valid <= 1'b0;
      error      <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      error      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_live) begin
            rd_q    <= mem_read;
            wr_q    <= mem_write;
            size_q  <= access_size;
            uns_q   <= load_unsigned;
            addr_q  <= address;
            wdata_q <= write_data;
            if (WAIT_CYCLES == 0) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= WaitInit;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
      if (go_resp) begin
        resp_valid <= 1'b1;
        error      <= acc_err;
        if (acc_err) begin
          read_data <= '0;
        end else if (acc_rd) begin
          read_data <= load_val;
        end
      end
    end
  end

  // Store commit at the end of the response cycle, so a reset in StResp still cancels it.
  always_ff @(posedge clk) begin
    if (!reset && state_q == StResp && wr_q && !acc_err) begin
      case (size_q)
        SizeWord: begin
          mem[a0] <= wdata_q[31:24];
          mem[a1] <= wdata_q[23:16];
          mem[a2] <= wdata_q[15:8];
          mem[a3] <= wdata_q[7:0];
        end
        SizeHalf: begin
          mem[a0] <= wdata_q[15:8];
          mem[a1] <= wdata_q[7:0];
        end
        SizeByte: begin
          mem[a0] <= wdata_q[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_data_memory_sync.sv
// Bench for mem_data_memory_sync with three wait states: directed cases followed by random
// accesses checked against a byte-array reference model.
module tb_mem_data_memory_sync;

  localparam int unsigned Aw    = 10;
  localparam int unsigned Waits = 3;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  access_size;
  logic        load_unsigned;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        resp_valid;
  logic        busy;
  logic        error;

  mem_data_memory_sync #(
    .ADDR_WIDTH (Aw),
    .WAIT_CYCLES(Waits),
    .DATA_WIDTH (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .access_size  (access_size),
    .load_unsigned(load_unsigned),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .resp_valid   (resp_valid),
    .busy         (busy),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state.
  int unsigned mm [1024];
  logic [31:0] exp_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit model_err(input bit rd, input bit wr, input int unsigned sz,
                                   input int unsigned addr);
    if (rd && wr) return 1'b1;
    if (sz == 3) return 1'b1;
    if (addr >= 1024) return 1'b1;
    if (sz == 0 && addr % 4 != 0) return 1'b1;
    if (sz == 1 && addr % 2 != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int unsigned model_load(input int unsigned sz, input bit uns,
                                             input int unsigned a);
    int unsigned v;
    if (sz == 0) begin
      v = mm[a] * 32'h0100_0000 + mm[a+1] * 32'h1_0000 + mm[a+2] * 32'h100 + mm[a+3];
    end else if (sz == 1) begin
      v = mm[a] * 256 + mm[a+1];
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = mm[a];
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end
    return v;
  endfunction

  // Apply one request to the model; updates storage and the expected read_data.
  task automatic model_apply(input bit rd, input bit wr, input int unsigned sz, input bit uns,
                             input int unsigned addr, input int unsigned wd, output bit err);
    err = model_err(rd, wr, sz, addr);
    if (err) begin
      exp_rd = 32'd0;
    end else if (wr) begin
      if (sz == 0) begin
        mm[addr]   = (wd / 32'h0100_0000) % 256;
        mm[addr+1] = (wd / 32'h1_0000) % 256;
        mm[addr+2] = (wd / 32'h100) % 256;
        mm[addr+3] = wd % 256;
      end else if (sz == 1) begin
        mm[addr]   = (wd / 256) % 256;
        mm[addr+1] = wd % 256;
      end else begin
        mm[addr] = wd % 256;
      end
    end else begin
      exp_rd = model_load(sz, uns, addr);
    end
  endtask

  // One full access: drive, check busy/latency/pulse, return the response.
  task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd, input bit hold,
                        output logic [31:0] rdata, output logic err);
    int k;
    @(negedge clk);
    mem_read      = rd;
    mem_write     = wr;
    access_size   = sz;
    load_unsigned = uns;
    address       = addr;
    write_data    = wd;
    #1 check("busy_accept", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (!resp_valid) check("busy_wait", {31'd0, busy}, 32'd1);
    end while (!resp_valid && k < 20);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    check("latency", k, Waits + 1);
    check("busy_resp", {31'd0, busy}, 32'd0);
    rdata = read_data;
    err   = error;
    @(negedge clk);
    check("resp_pulse", {31'd0, resp_valid}, 32'd0);
  endtask

  // Access checked against the model.
  task automatic op(input string tag, input bit rd, input bit wr, input int unsigned sz,
                    input bit uns, input int unsigned addr, input int unsigned wd,
                    input bit hold);
    logic [31:0] got;
    logic        gerr;
    bit          eerr;
    access(rd, wr, sz[1:0], uns, addr, wd, hold, got, gerr);
    model_apply(rd, wr, sz, uns, addr, wd, eerr);
    check({tag, "_err"}, {31'd0, gerr}, {31'd0, eerr});
    check({tag, "_data"}, got, exp_rd);
  endtask

  // Directed load against a literal value.
  task automatic load_expect(input string tag, input int unsigned sz, input bit uns,
                             input int unsigned addr, input logic [31:0] exp_val,
                             input bit exp_err);
    logic [31:0] got;
    logic        gerr;
    bit          eerr;
    access(1'b1, 1'b0, sz[1:0], uns, addr, 32'd0, 1'b0, got, gerr);
    model_apply(1'b1, 1'b0, sz, uns, addr, 0, eerr);
    check({tag, "_err"}, {31'd0, gerr}, {31'd0, exp_err});
    check({tag, "_data"}, got, exp_val);
  endtask

  initial begin
    bit any_resp;
    bit eerr;
    reset         = 1'b1;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    access_size   = 2'b00;
    load_unsigned = 1'b0;
    address       = 32'd0;
    write_data    = 32'd0;
    exp_rd        = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_read_data", read_data, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);

    // Fill the low 256 bytes so the model knows every byte it may read back.
    for (int i = 0; i < 64; i++) op("fill", 1'b0, 1'b1, 0, 1'b0, i * 4, $urandom, 1'b0);

    op("st_deadbeef", 1'b0, 1'b1, 0, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
    load_expect("ld_w10", 0, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
    load_expect("ld_h10_s", 1, 1'b0, 32'h10, 32'hFFFF_DEAD, 1'b0);
    load_expect("ld_h10_u", 1, 1'b1, 32'h10, 32'h0000_DEAD, 1'b0);
    load_expect("ld_b13_s", 2, 1'b0, 32'h13, 32'hFFFF_FFEF, 1'b0);
    op("st_b11", 1'b0, 1'b1, 2, 1'b0, 32'h11, 32'h0000_005A, 1'b0);
    load_expect("ld_w10_b", 0, 1'b0, 32'h10, 32'hDE5A_BEEF, 1'b0);
    load_expect("ld_w12_mis", 0, 1'b0, 32'h12, 32'h0, 1'b1);
    op("st_h401", 1'b0, 1'b1, 1, 1'b0, 32'h401, 32'h0000_1234, 1'b0);
    // Requests held high through the wait cycles must not start a second access.
    op("hold_ld", 1'b1, 1'b0, 0, 1'b0, 32'h10, 0, 1'b1);
    check("hold_idle_busy", {31'd0, busy}, 32'd0);
    load_expect("ld_w10_c", 0, 1'b0, 32'h10, 32'hDE5A_BEEF, 1'b0);

    // Reset one cycle after a store is accepted cancels it.
    op("st_old", 1'b0, 1'b1, 0, 1'b0, 32'h20, 32'h1122_3344, 1'b0);
    @(negedge clk);
    mem_write   = 1'b1;
    access_size = 2'b00;
    address     = 32'h20;
    write_data  = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_rd   = 32'd0;
    any_resp = 1'b0;
    for (int i = 0; i < Waits + 3; i++) begin
      @(negedge clk);
      if (resp_valid) any_resp = 1'b1;
    end
    check("abort_no_resp", {31'd0, any_resp}, 32'd0);
    check("abort_rd_cleared", read_data, 32'd0);
    load_expect("abort_old", 0, 1'b0, 32'h20, 32'h1122_3344, 1'b0);

    // Random mix of loads, stores and erroneous requests.
    for (int i = 0; i < 300; i++) begin
      int unsigned sel;
      int unsigned sz;
      int unsigned addr;
      bit          rd;
      bit          wr;
      sel = $urandom_range(0, 19);
      rd  = (sel < 9) || (sel == 19);
      wr  = (sel >= 9);
      sz  = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
      addr = $urandom_range(0, 255);
      if ($urandom_range(0, 4) != 0) begin
        if (sz == 0) addr = addr - addr % 4;
        if (sz == 1) addr = addr - addr % 2;
      end
      if ($urandom_range(0, 19) == 0) addr = addr | (32'd1 << $urandom_range(Aw, 31));
      op("rand", rd, wr, sz, 1'($urandom), addr, $urandom, 1'b0);
    end
    eerr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
